// File: rtl/core_pkg.sv
// Shared types for the core execution blocks: ALU opcodes, divider opcodes
// and the divider controller state encoding.
package core_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_OA  = 2'd2,
    ALU_OB  = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/core_alu.sv
// Small combinational ALU shared by the divider for trial subtracts and
// sign fix-up negation.
module core_alu
  import core_pkg::*;
(
  input  alu_op_e     i_alu_op,
  input  logic [31:0] i_src_a,
  input  logic [31:0] i_src_b,
  output logic [31:0] o_result
);

  // Operation select
  always_comb begin
    o_result = 32'd0;
    case (i_alu_op)
      ALU_ADD: o_result = i_src_a + i_src_b;
      ALU_SUB: o_result = i_src_a - i_src_b;
      ALU_OA:  o_result = i_src_a;
      ALU_OB:  o_result = i_src_b;
      default: o_result = 32'd0;
    endcase
  end

endmodule

// File: rtl/core_div_ctrl.sv
// Iterative 32-bit restoring divider: one quotient bit per CALC cycle,
// sign fix-up in FIX, result held in DONE until the consumer accepts it.
module core_div_ctrl
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  div_op_e     req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        busy
);

  div_state_e  r_state;
  div_state_e  w_state_nxt;
  div_op_e     r_op;
  logic [5:0]  r_cnt;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_div;
  logic [31:0] r_result;
  logic        r_sign_a;
  logic        r_sign_b;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_busy;

  logic        w_accept;
  logic        w_signed_op;
  logic        w_div_zero;
  logic        w_ovf;
  logic        w_take;
  logic        w_fix_neg;
  logic [31:0] w_rem_sh;
  logic [31:0] w_fix_val;
  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_res;
  alu_op_e     w_alu_op;
  logic        w_req_ready_nxt;
  logic        w_resp_valid_nxt;
  logic        w_busy_nxt;

  assign w_accept    = (r_state == IDLE) && r_req_ready && req_valid && !flush;
  assign w_signed_op = (req_op == DIV) || (req_op == REM);
  assign w_div_zero  = (req_b == 32'd0);
  assign w_ovf       = w_signed_op && (req_a == 32'h8000_0000) && (req_b == 32'hFFFF_FFFF);

  // The bit leaving r_rem[31] makes the true partial remainder 33 bits wide
  assign w_rem_sh  = {r_rem[30:0], r_quo[31]};
  assign w_take    = r_rem[31] || (w_rem_sh >= r_div);
  assign w_fix_val = ((r_op == DIV) || (r_op == DIVU)) ? r_quo : r_rem;
  assign w_fix_neg = ((r_op == DIV) && (r_sign_a ^ r_sign_b)) || ((r_op == REM) && r_sign_a);

  core_alu u_alu (
    .i_alu_op (w_alu_op),
    .i_src_a  (w_alu_a),
    .i_src_b  (w_alu_b),
    .o_result (w_alu_res)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_state_nxt = (w_div_zero || w_ovf) ? DONE : CALC;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        CALC: begin
          if (r_cnt == 6'd31) begin
            w_state_nxt = FIX;
          end else begin
            w_state_nxt = CALC;
          end
        end
        FIX: w_state_nxt = DONE;
        DONE: begin
          if (r_resp_valid && resp_ready) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DONE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Output decode (registered from next state) and ALU operand steering
  always_comb begin
    w_req_ready_nxt  = (w_state_nxt == IDLE);
    w_resp_valid_nxt = (w_state_nxt == DONE);
    w_busy_nxt       = (w_state_nxt != IDLE);
    w_alu_op         = ALU_OA;
    w_alu_a          = 32'd0;
    w_alu_b          = 32'd0;
    case (r_state)
      CALC: begin
        w_alu_op = ALU_SUB;
        w_alu_a  = w_rem_sh;
        w_alu_b  = r_div;
      end
      FIX: begin
        w_alu_op = ALU_SUB;
        w_alu_a  = 32'd0;
        w_alu_b  = w_fix_val;
      end
      default: begin
        w_alu_op = ALU_OA;
        w_alu_a  = 32'd0;
        w_alu_b  = 32'd0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Datapath: operand capture, shift/subtract iteration and sign fix-up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= DIV;
      r_cnt    <= 6'd0;
      r_quo    <= 32'd0;
      r_rem    <= 32'd0;
      r_div    <= 32'd0;
      r_result <= 32'd0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op     <= req_op;
            r_sign_a <= w_signed_op & req_a[31];
            r_sign_b <= w_signed_op & req_b[31];
            r_quo    <= (w_signed_op && req_a[31]) ? -req_a : req_a;
            r_div    <= (w_signed_op && req_b[31]) ? -req_b : req_b;
            r_rem    <= 32'd0;
            r_cnt    <= 6'd0;
            if (w_div_zero) begin
              r_result <= ((req_op == DIV) || (req_op == DIVU)) ? 32'hFFFF_FFFF : req_a;
            end else if (w_ovf) begin
              r_result <= (req_op == DIV) ? 32'h8000_0000 : 32'd0;
            end
          end
        end
        CALC: begin
          r_rem <= w_take ? w_alu_res : w_rem_sh;
          r_quo <= {r_quo[30:0], w_take};
          r_cnt <= r_cnt + 6'd1;
        end
        FIX: r_result <= w_fix_neg ? w_alu_res : w_fix_val;
        default: begin
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign busy        = r_busy;
  assign resp_result = r_result;

endmodule

// File: tb/tb_core_div_ctrl.sv
// Self-checking bench for core_div_ctrl: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_core_div_ctrl;
  import core_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  div_op_e     req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  core_div_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic plus the two architectural special cases
  function automatic logic [31:0] model(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return ((op == DIV) || (op == DIVU)) ? 32'hFFFF_FFFF : a;
    if (((op == DIV) || (op == REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return (op == DIV) ? 32'h8000_0000 : 32'd0;
    case (op)
      DIV:     return sa / sb;
      REM:     return sa % sb;
      DIVU:    return a / b;
      default: return a % b;
    endcase
  endfunction

  function automatic int model_lat(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (((op == DIV) || (op == REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic run_op(input div_op_e op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int          lat;
    int          c;
    exp = model(op, a, b);
    lat = model_lat(op, a, b);
    @(negedge clk);
    c = 0;
    while (!req_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!resp_valid && c < 60);
    chk("latency", c, lat);
    chk("result", resp_result, exp);
    chk("ready_low_done", {31'd0, req_ready}, 32'd0);
    chk("busy_done", {31'd0, busy}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_result", resp_result, exp);
      chk("hold_ready_low", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("valid_after_hs", {31'd0, resp_valid}, 32'd0);
    chk("ready_after_hs", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    div_op_e     rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          c;
    rst_n      = 1'b0;
    flush      = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    req_op     = DIV;
    req_a      = 32'd0;
    req_b      = 32'd0;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", resp_result, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    run_op(DIVU, 32'd100, 32'd7, 0);
    run_op(REMU, 32'd100, 32'd7, 1);
    run_op(DIV,  32'hFFFF_FF9C, 32'd7, 0);
    run_op(REM,  32'hFFFF_FF9C, 32'd7, 0);
    run_op(DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    run_op(REMU, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    run_op(DIV,  32'd5, 32'd0, 0);
    run_op(REM,  32'd5, 32'd0, 0);
    run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(DIV,  32'h8000_0000, 32'd1, 0);
    run_op(DIVU, 32'd1000, 32'd3, 5);

    // Flush in the middle of CALC
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = DIVU;
    req_a     = 32'd100;
    req_b     = 32'd7;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_ready", {31'd0, req_ready}, 32'd1);
    c = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) c++;
    end
    chk("flush_no_resp", c, 0);

    // Request coinciding with flush must be ignored
    req_valid = 1'b1;
    flush     = 1'b1;
    req_op    = DIVU;
    req_a     = 32'd50;
    req_b     = 32'd5;
    @(posedge clk);
    #1 begin
      req_valid = 1'b0;
      flush     = 1'b0;
    end
    @(negedge clk);
    chk("flush_blocks_req", {31'd0, busy}, 32'd0);
    run_op(DIVU, 32'd9, 32'd3, 0);

    // Reset mid-CALC
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = DIV;
    req_a     = 32'd12345;
    req_b     = 32'd17;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, req_ready}, 32'd0);
    chk("midrst_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_result", resp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", {31'd0, req_ready}, 32'd1);
    chk("midrst_no_resp", {31'd0, resp_valid}, 32'd0);

    // Randomized operations
    for (int k = 0; k < 24; k++) begin
      rop = div_op_e'($urandom_range(3, 0));
      ra  = $urandom;
      case ($urandom_range(4, 0))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(15, 1);
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(7, 0) == 0) ra = 32'h8000_0000;
      run_op(rop, ra, rb, $urandom_range(3, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
